// File: rtl/ex_commit_if.sv
// EX-to-MEM bundle for ex_commit: EX instruction/ALU results in,
// registered valid/ready result out toward the EX/MEM boundary.
interface ex_commit_if;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic [4:0]  rd_addr_i;
  logic        reg_we_i;
  logic [31:0] add_res_i;
  logic [31:0] sub_res_i;
  logic [31:0] and_res_i;
  logic [31:0] or_res_i;
  logic [31:0] xor_res_i;
  logic [31:0] slt_res_i;
  logic [31:0] sltu_res_i;
  logic [31:0] sll_res_i;
  logic [31:0] srl_res_i;
  logic [31:0] sra_res_i;
  logic [31:0] jump_addr_res_i;
  logic        rs1_eq_rs2_i;
  logic        rs1_lt_rs2_i;
  logic        rs1_lt_rs2_u_i;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_inst_addr_o;
  logic [4:0]  mem_rd_addr_o;
  logic        mem_reg_we_o;
  logic [31:0] mem_wdata_o;

  modport slave (
    input  ex_valid_i, inst_i, inst_addr_i, rd_addr_i, reg_we_i,
    input  add_res_i, sub_res_i, and_res_i, or_res_i, xor_res_i,
    input  slt_res_i, sltu_res_i, sll_res_i, srl_res_i, sra_res_i,
    input  jump_addr_res_i, rs1_eq_rs2_i, rs1_lt_rs2_i, rs1_lt_rs2_u_i,
    input  mem_ready_i,
    output ex_ready_o, mem_valid_o, mem_inst_addr_o, mem_rd_addr_o,
    output mem_reg_we_o, mem_wdata_o
  );

  modport master (
    output ex_valid_i, inst_i, inst_addr_i, rd_addr_i, reg_we_i,
    output add_res_i, sub_res_i, and_res_i, or_res_i, xor_res_i,
    output slt_res_i, sltu_res_i, sll_res_i, srl_res_i, sra_res_i,
    output jump_addr_res_i, rs1_eq_rs2_i, rs1_lt_rs2_i, rs1_lt_rs2_u_i,
    output mem_ready_i,
    input  ex_ready_o, mem_valid_o, mem_inst_addr_o, mem_rd_addr_o,
    input  mem_reg_we_o, mem_wdata_o
  );
endinterface

// File: rtl/ex_commit.sv
// TinyRISC-V EX commit: picks the ALU result for the EX instruction, resolves
// branches/jumps, and holds the outcome in a one-entry valid/ready register.
module ex_commit (
  input  logic        clk,
  input  logic        rst_n,
  ex_commit_if.slave  bus,
  input  logic        flush_i,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_f7b5;
  logic [31:0] w_wdata;
  logic        w_we;
  logic        w_taken;
  logic [31:0] w_target;
  logic        w_ex_ready;
  logic        w_accept;

  logic        r_mem_valid;
  logic [31:0] r_mem_inst_addr;
  logic [4:0]  r_mem_rd_addr;
  logic        r_mem_reg_we;
  logic [31:0] r_mem_wdata;
  logic        r_jump_flag;
  logic [31:0] r_jump_addr;

  assign w_opcode = bus.inst_i[6:0];
  assign w_funct3 = bus.inst_i[14:12];
  assign w_f7b5   = bus.inst_i[30];

  always_comb begin
    w_wdata  = bus.add_res_i;
    w_we     = bus.reg_we_i;
    w_taken  = 1'b0;
    w_target = bus.jump_addr_res_i;
    case (w_opcode)
      OP_R, OP_I: begin
        case (w_funct3)
          3'b000: w_wdata = (w_opcode == OP_R && w_f7b5) ? bus.sub_res_i : bus.add_res_i;
          3'b001: w_wdata = bus.sll_res_i;
          3'b010: w_wdata = bus.slt_res_i;
          3'b011: w_wdata = bus.sltu_res_i;
          3'b100: w_wdata = bus.xor_res_i;
          3'b101: w_wdata = w_f7b5 ? bus.sra_res_i : bus.srl_res_i;
          3'b110: w_wdata = bus.or_res_i;
          default: w_wdata = bus.and_res_i;
        endcase
      end
      OP_LUI, OP_AUIPC: w_wdata = bus.add_res_i;
      OP_JAL: begin
        w_wdata = bus.inst_addr_i + 32'd4;
        w_taken = 1'b1;
      end
      OP_JALR: begin
        w_wdata  = bus.inst_addr_i + 32'd4;
        w_taken  = 1'b1;
        w_target = {bus.jump_addr_res_i[31:1], 1'b0};
      end
      OP_BRANCH: begin
        w_we = 1'b0;
        case (w_funct3)
          3'b000:  w_taken = bus.rs1_eq_rs2_i;
          3'b001:  w_taken = !bus.rs1_eq_rs2_i;
          3'b100:  w_taken = bus.rs1_lt_rs2_i;
          3'b101:  w_taken = !bus.rs1_lt_rs2_i;
          3'b110:  w_taken = bus.rs1_lt_rs2_u_i;
          3'b111:  w_taken = !bus.rs1_lt_rs2_u_i;
          default: w_taken = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  // Ready ignores flush; the instruction in the jump shadow is consumed but dropped.
  assign w_ex_ready = !r_mem_valid || bus.mem_ready_i;
  assign w_accept   = bus.ex_valid_i && w_ex_ready && !flush_i && !r_jump_flag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_valid     <= 1'b0;
      r_mem_inst_addr <= 32'd0;
      r_mem_rd_addr   <= 5'd0;
      r_mem_reg_we    <= 1'b0;
      r_mem_wdata     <= 32'd0;
      r_jump_flag     <= 1'b0;
      r_jump_addr     <= 32'd0;
    end else if (flush_i) begin
      r_mem_valid <= 1'b0;
      r_jump_flag <= 1'b0;
    end else if (w_accept) begin
      r_mem_valid     <= 1'b1;
      r_mem_inst_addr <= bus.inst_addr_i;
      r_mem_rd_addr   <= bus.rd_addr_i;
      r_mem_reg_we    <= w_we;
      r_mem_wdata     <= w_wdata;
      r_jump_flag     <= w_taken;
      if (w_taken) begin
        r_jump_addr <= w_target;
      end
    end else begin
      // The redirect pulse is single-cycle regardless of downstream stalls.
      r_jump_flag <= 1'b0;
      if (bus.mem_ready_i) begin
        r_mem_valid <= 1'b0;
      end
    end
  end

  assign bus.ex_ready_o      = w_ex_ready;
  assign bus.mem_valid_o     = r_mem_valid;
  assign bus.mem_inst_addr_o = r_mem_inst_addr;
  assign bus.mem_rd_addr_o   = r_mem_rd_addr;
  assign bus.mem_reg_we_o    = r_mem_reg_we;
  assign bus.mem_wdata_o     = r_mem_wdata;
  assign jump_flag_o         = r_jump_flag;
  assign jump_addr_o         = r_jump_addr;
endmodule
